opcode_entry_encoder: RTL and testbench
=======================================

# opcode_entry_encoder

Operator-input front end for the DE1 pipelined-CPU board. Converts three raw active-low pushbuttons into a selected instruction mnemonic and issues its 11-bit opcode to the CPU over a valid/ready handshake. It is the encoding counterpart of the opcode-to-mnemonic HEX display path: it produces exactly the opcode set that path decodes. `sel_index` and `op_out` can drive the existing display so the operator sees the pending choice.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable samples required to accept a key level change (20 ms at 50 MHz).
- `REPEAT_CYCLES`, default 12_500_000: auto-repeat period, used only when `OPENC_AUTOREPEAT_EN` is defined.
- `CLOCK_50` in, 1: sole clock, rising edge.
- `PHReset` in, 1: reset, asynchronous, active-low.
- `key_next_n` in, 1: raw pushbutton, active-low, asynchronous to `CLOCK_50`.
- `key_prev_n` in, 1: raw pushbutton, active-low, asynchronous.
- `key_issue_n` in, 1: raw pushbutton, active-low, asynchronous.
- `op_ready` in, 1: CPU accepts the opcode.
- `op_out` out, 11: opcode offered to the CPU.
- `op_valid` out, 1: `op_out` is valid.
- `sel_index` out, 4: current table index, 0–12.
- `issue_count` out, 8: completed transfers, wraps 255→0.

## Operation
- Opcode table, indices 0–12:
  - 0 NOP 0x000, 1 ADD 0x458, 2 SUB 0x658, 3 AND 0x450, 4 ORR 0x550
  - 5 EOR 0x650, 6 LSL 0x69B, 7 LDURSW 0x5C4, 8 STURW 0x5C0
  - 9 B 0x0A0, 10 BR 0x6B0, 11 BGT 0x2A0, 12 ADDI 0x488
- Key conditioning, per key:
  - 2-flop synchronizer, then debouncer.
  - Debounced level (reset value 1) changes only after `DEBOUNCE_CYCLES` consecutive synchronized samples differ from it. Any bounce restarts the count.
  - A debounced 1→0 transition produces a one-cycle press pulse. Release produces no pulse.
- Navigation:
  - Next pulse: `sel_index` +1, wrapping 12→0.
  - Prev pulse: `sel_index` −1, wrapping 0→12.
  - Next and prev pulses in the same cycle: no change.
- FSM states: IDLE, OFFER.
  - IDLE: `op_valid`=0; navigation active. An issue pulse latches `op_out`=table[`sel_index`] and moves to OFFER.
  - OFFER: `op_valid`=1; `op_out` and `sel_index` frozen; next, prev and issue pulses are discarded, not queued.
  - OFFER with `op_ready`=1: transfer completes, `issue_count` +1, return to IDLE.
- Issue pulse coinciding with a next or prev pulse in IDLE: the pre-update index is latched, then the index updates.
- `op_out` holds its last issued value in IDLE.
- `PHReset` asserted mid-OFFER: aborts without counting; all state returns to reset values.

## Timing
- Reset values:
  - `op_out`=0x000, `op_valid`=0, `sel_index`=0, `issue_count`=0, FSM=IDLE.
  - Debounced levels=1; debounce and repeat counters=0.
- Press pulse latency: raw key low and held at cycle 0 gives the pulse at cycle `DEBOUNCE_CYCLES`+2.
- `sel_index` and `op_valid` update on the edge after the pulse (registered outputs).
- Transfer occurs on the edge where `op_valid`&`op_ready`=1. `op_valid` is 0 on the following cycle.
- Back-to-back issue is limited by key latency. Minimum OFFER duration is 1 cycle.

## Configuration
- `OPENC_AUTOREPEAT_EN` defined:
  - While next or prev stays debounced-low in IDLE, extra pulses are generated every `REPEAT_CYCLES` after the initial press pulse.
  - The repeat counter clears on release or on entering OFFER.
  - Issue never repeats.
- `OPENC_AUTOREPEAT_EN` not defined: exactly one pulse per press; no repeat counters are synthesized.

## Structure
- Package `opcode_pkg`:
  - 11-bit opcode constants and the 13-entry table function.
  - `NUM_OPS`=13 and index width 4.
  - FSM state enum {IDLE, OFFER}.
  - The HEX display decoder reuses the same constants.
- Sub-module `key_debouncer`, instantiated three times. It contains the synchronizer, debounce counter and press-pulse output.

## Test plan
Simulate with `DEBOUNCE_CYCLES`=4 and `REPEAT_CYCLES`=8.
- Reset, then hold issue with `op_ready`=1 → `op_out`=0x000 (NOP), one transfer, `issue_count`=1.
- Press next 13 times → `sel_index` goes 1…12, then 0; `op_out` unchanged.
- Press prev once from 0 → `sel_index`=12; issue → `op_out`=0x488, `op_valid` held until `op_ready`.
- In OFFER with `op_ready`=0 for 50 cycles, press next and issue → `sel_index`, `op_out` and `issue_count` unchanged. Raise `op_ready` → single transfer.
- Raw next toggling every 2 cycles for 40 cycles, then held low → exactly one pulse, at hold start +6 cycles.
- Assert `PHReset` during OFFER → `op_valid`=0 and `sel_index`=0 immediately (async), `issue_count`=0. With the macro defined, holding next for 30 cycles past the first pulse gives 3 repeat increments.

Source files
------------

// File: rtl/opcode_pkg.sv
// Shared opcode constants for the operator-entry path and the HEX display decoder.
// Contents: opcode width/table size, 11-bit opcode constants, the 13-entry
// index-to-opcode table function and the entry FSM state enum.
package opcode_pkg;

  localparam int unsigned OP_W    = 11;
  localparam int unsigned NUM_OPS = 13;
  localparam int unsigned IDX_W   = 4;

  localparam logic [OP_W-1:0] OP_NOP    = 11'h000;
  localparam logic [OP_W-1:0] OP_ADD    = 11'h458;
  localparam logic [OP_W-1:0] OP_SUB    = 11'h658;
  localparam logic [OP_W-1:0] OP_AND    = 11'h450;
  localparam logic [OP_W-1:0] OP_ORR    = 11'h550;
  localparam logic [OP_W-1:0] OP_EOR    = 11'h650;
  localparam logic [OP_W-1:0] OP_LSL    = 11'h69B;
  localparam logic [OP_W-1:0] OP_LDURSW = 11'h5C4;
  localparam logic [OP_W-1:0] OP_STURW  = 11'h5C0;
  localparam logic [OP_W-1:0] OP_B      = 11'h0A0;
  localparam logic [OP_W-1:0] OP_BR     = 11'h6B0;
  localparam logic [OP_W-1:0] OP_BGT    = 11'h2A0;
  localparam logic [OP_W-1:0] OP_ADDI   = 11'h488;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } entry_state_e;

  // Table index to opcode; out-of-range indices map to NOP.
  function automatic logic [OP_W-1:0] opcode_lookup(input logic [IDX_W-1:0] idx);
    logic [OP_W-1:0] op;
    case (idx)
      4'd0:    op = OP_NOP;
      4'd1:    op = OP_ADD;
      4'd2:    op = OP_SUB;
      4'd3:    op = OP_AND;
      4'd4:    op = OP_ORR;
      4'd5:    op = OP_EOR;
      4'd6:    op = OP_LSL;
      4'd7:    op = OP_LDURSW;
      4'd8:    op = OP_STURW;
      4'd9:    op = OP_B;
      4'd10:   op = OP_BR;
      4'd11:   op = OP_BGT;
      4'd12:   op = OP_ADDI;
      default: op = OP_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Conditions one raw active-low pushbutton: 2-flop synchronizer, debounce
// counter and a one-cycle pulse on a debounced press (1->0).
// Ports: clk, rst_n (async active-low), key_n (raw, asynchronous),
//        level_o (debounced level, reset 1), press_o (one-cycle press pulse).
module key_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic level_o,
  output logic press_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;

  // Level flips after DEBOUNCE_CYCLES consecutive differing samples; any agreeing sample restarts.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync_q[1];
        cnt_d   = '0;
        press_d = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      level_q <= 1'b1;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_n};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/opcode_entry_encoder.sv
// Operator front end: three pushbuttons select a mnemonic from the opcode table
// and issue its 11-bit opcode to the CPU over a valid/ready handshake.
// Ports: CLOCK_50, PHReset (async active-low), key_next_n/key_prev_n/key_issue_n
//        (raw active-low), op_ready in; op_out, op_valid, sel_index, issue_count out.
// Optional feature: OPENC_AUTOREPEAT_EN enables auto-repeat on next/prev.
module opcode_entry_encoder
  import opcode_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_CYCLES   = 12_500_000
) (
  input  logic             CLOCK_50,
  input  logic             PHReset,
  input  logic             key_next_n,
  input  logic             key_prev_n,
  input  logic             key_issue_n,
  input  logic             op_ready,
  output logic [OP_W-1:0]  op_out,
  output logic             op_valid,
  output logic [IDX_W-1:0] sel_index,
  output logic [7:0]       issue_count
);

  logic lvl_next_c, lvl_prev_c, lvl_issue_c;
  logic press_next_c, press_prev_c, press_issue_c;
  logic nav_next_c, nav_prev_c;

  entry_state_e     state_q, state_d;
  logic [OP_W-1:0]  op_out_q, op_out_d;
  logic             op_valid_q, op_valid_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [7:0]       cnt_q, cnt_d;

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk(CLOCK_50), .rst_n(PHReset), .key_n(key_next_n),
    .level_o(lvl_next_c), .press_o(press_next_c)
  );
  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
    .clk(CLOCK_50), .rst_n(PHReset), .key_n(key_prev_n),
    .level_o(lvl_prev_c), .press_o(press_prev_c)
  );
  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_issue (
    .clk(CLOCK_50), .rst_n(PHReset), .key_n(key_issue_n),
    .level_o(lvl_issue_c), .press_o(press_issue_c)
  );

`ifdef OPENC_AUTOREPEAT_EN
  localparam int unsigned RPT_W = $clog2(REPEAT_CYCLES + 1);

  logic [RPT_W-1:0] rpt_next_q, rpt_next_d, rpt_prev_q, rpt_prev_d;
  logic             rpt_next_c, rpt_prev_c;
  logic             unused_ok_c;

  // Repeat counters run only while the key is held in IDLE, starting after the press pulse.
  always_comb begin
    rpt_next_d = '0;
    rpt_prev_d = '0;
    rpt_next_c = 1'b0;
    rpt_prev_c = 1'b0;
    if (state_q == IDLE && !lvl_next_c && !press_next_c) begin
      if (rpt_next_q == RPT_W'(REPEAT_CYCLES - 1)) rpt_next_c = 1'b1;
      else                                         rpt_next_d = rpt_next_q + 1'b1;
    end
    if (state_q == IDLE && !lvl_prev_c && !press_prev_c) begin
      if (rpt_prev_q == RPT_W'(REPEAT_CYCLES - 1)) rpt_prev_c = 1'b1;
      else                                         rpt_prev_d = rpt_prev_q + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge PHReset) begin
    if (!PHReset) begin
      rpt_next_q <= '0;
      rpt_prev_q <= '0;
    end else begin
      rpt_next_q <= rpt_next_d;
      rpt_prev_q <= rpt_prev_d;
    end
  end

  assign nav_next_c  = press_next_c | rpt_next_c;
  assign nav_prev_c  = press_prev_c | rpt_prev_c;
  assign unused_ok_c = lvl_issue_c;
`else
  logic unused_ok_c;

  assign nav_next_c  = press_next_c;
  assign nav_prev_c  = press_prev_c;
  assign unused_ok_c = &{lvl_next_c, lvl_prev_c, lvl_issue_c, (REPEAT_CYCLES != 32'd0)};
`endif

  // Entry FSM: navigation and issue in IDLE, hold offer until the CPU accepts.
  always_comb begin
    state_d    = state_q;
    op_out_d   = op_out_q;
    op_valid_d = op_valid_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        op_valid_d = 1'b0;
        if (nav_next_c && !nav_prev_c) begin
          sel_d = (sel_q == IDX_W'(NUM_OPS - 1)) ? '0 : sel_q + 1'b1;
        end else if (nav_prev_c && !nav_next_c) begin
          sel_d = (sel_q == '0) ? IDX_W'(NUM_OPS - 1) : sel_q - 1'b1;
        end
        // Issue latches the pre-navigation index.
        if (press_issue_c) begin
          op_out_d   = opcode_lookup(sel_q);
          op_valid_d = 1'b1;
          state_d    = OFFER;
        end
      end
      OFFER: begin
        op_valid_d = 1'b1;
        if (op_ready) begin
          op_valid_d = 1'b0;
          cnt_d      = cnt_q + 1'b1;
          state_d    = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge PHReset) begin
    if (!PHReset) begin
      state_q    <= IDLE;
      op_out_q   <= OP_NOP;
      op_valid_q <= 1'b0;
      sel_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_out_q   <= op_out_d;
      op_valid_q <= op_valid_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
    end
  end

  assign op_out      = op_out_q;
  assign op_valid    = op_valid_q;
  assign sel_index   = sel_q;
  assign issue_count = cnt_q;

endmodule

// File: tb/tb_opcode_entry_encoder.sv
// Directed bench for opcode_entry_encoder with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_opcode_entry_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_next_n, key_prev_n, key_issue_n;
  logic        op_ready;
  logic [10:0] op_out;
  logic        op_valid;
  logic [3:0]  sel_index;
  logic [7:0]  issue_count;

  int total  = 0;
  int passed = 0;

  opcode_entry_encoder #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(8)) dut (
    .CLOCK_50(clk), .PHReset(rst_n),
    .key_next_n(key_next_n), .key_prev_n(key_prev_n), .key_issue_n(key_issue_n),
    .op_ready(op_ready), .op_out(op_out), .op_valid(op_valid),
    .sel_index(sel_index), .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; key_next_n = 1'b1; key_prev_n = 1'b1; key_issue_n = 1'b1; op_ready = 1'b0;
    tick(3);
    chk("rst_op_out", 32'(op_out), 32'h000);
    chk("rst_op_valid", 32'(op_valid), 32'd0);
    chk("rst_sel", 32'(sel_index), 32'd0);
    chk("rst_count", 32'(issue_count), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Issue NOP with the CPU ready: offer appears at edge 7, transfer at edge 8.
    op_ready = 1'b1;
    key_issue_n = 1'b0;
    tick(7);
    chk("nop_valid", 32'(op_valid), 32'd1);
    chk("nop_op_out", 32'(op_out), 32'h000);
    tick(1);
    chk("nop_valid_after", 32'(op_valid), 32'd0);
    chk("nop_count", 32'(issue_count), 32'd1);
    key_issue_n = 1'b1;
    tick(8);
    chk("nop_single_transfer", 32'(issue_count), 32'd1);

    // Thirteen next presses walk 1..12 then wrap to 0.
    for (int i = 1; i <= 13; i++) begin
      key_next_n = 1'b0;
      tick(7);
      chk($sformatf("next_%0d", i), 32'(sel_index), 32'(i % 13));
      key_next_n = 1'b1;
      tick(8);
    end
    chk("next_op_out_unchanged", 32'(op_out), 32'h000);

    // Prev from 0 wraps to 12; issue ADDI with the CPU stalled.
    op_ready = 1'b0;
    key_prev_n = 1'b0;
    tick(7);
    chk("prev_wrap", 32'(sel_index), 32'd12);
    key_prev_n = 1'b1;
    tick(8);
    key_issue_n = 1'b0;
    tick(7);
    chk("addi_valid", 32'(op_valid), 32'd1);
    chk("addi_op_out", 32'(op_out), 32'h488);
    key_issue_n = 1'b1;
    tick(8);
    chk("addi_valid_held", 32'(op_valid), 32'd1);

    // Keys pressed during OFFER are discarded.
    tick(30);
    key_next_n = 1'b0;  tick(7); key_next_n = 1'b1;  tick(8);
    key_issue_n = 1'b0; tick(7); key_issue_n = 1'b1; tick(8);
    chk("offer_sel_frozen", 32'(sel_index), 32'd12);
    chk("offer_op_out_frozen", 32'(op_out), 32'h488);
    chk("offer_count_frozen", 32'(issue_count), 32'd1);
    chk("offer_valid_held", 32'(op_valid), 32'd1);
    op_ready = 1'b1;
    tick(1);
    chk("offer_xfer_valid", 32'(op_valid), 32'd0);
    chk("offer_xfer_count", 32'(issue_count), 32'd2);
    op_ready = 1'b0;
    tick(3);
    chk("offer_no_requeue", 32'(issue_count), 32'd2);

    // Bouncing next for 40 cycles, then a steady hold: one pulse at hold start + 6.
    for (int i = 0; i < 20; i++) begin
      key_next_n = ~key_next_n;
      tick(2);
    end
    chk("bounce_no_pulse", 32'(sel_index), 32'd12);
    key_next_n = 1'b0;
    tick(6);
    chk("hold_before_update", 32'(sel_index), 32'd12);
    tick(1);
    chk("hold_single_pulse", 32'(sel_index), 32'd0);
    tick(24);
`ifdef OPENC_AUTOREPEAT_EN
    chk("hold_repeat", 32'(sel_index), 32'd3);
`else
    chk("hold_repeat", 32'(sel_index), 32'd0);
`endif
    key_next_n = 1'b1;
    tick(10);
`ifdef OPENC_AUTOREPEAT_EN
    chk("release_repeat", 32'(sel_index), 32'd3);
`else
    chk("release_repeat", 32'(sel_index), 32'd0);
`endif

    // Reset during OFFER aborts without counting.
    key_issue_n = 1'b0;
    tick(7);
    chk("pre_reset_valid", 32'(op_valid), 32'd1);
    key_issue_n = 1'b1;
    tick(3);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(op_valid), 32'd0);
    chk("async_rst_sel", 32'(sel_index), 32'd0);
    chk("async_rst_count", 32'(issue_count), 32'd0);
    chk("async_rst_op_out", 32'(op_out), 32'h000);
    tick(2);
    rst_n = 1'b1;
    tick(10);
    chk("post_rst_idle", 32'(op_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
